// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame sequencer: captures this node's first pixel of each frame, then
// forwards the remaining bits downstream until the line latches low.
module ws2812_frame_ctrl #(
  parameter int RESET_CYCLES  = 2500,
  parameter int LOW_CNT_WIDTH = 12,
  parameter int PIXEL_BITS    = 24
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_rx,
  input  logic                  i_bit_strobe,
  input  logic                  i_bit_value,
  input  logic                  i_bit_error,
  output logic [PIXEL_BITS-1:0] o_pixel_data,
  output logic                  o_pixel_valid,
  input  logic                  i_pixel_ready,
  output logic                  o_fwd_en,
  output logic                  o_frame_done,
  output logic                  o_overrun,
  output logic [7:0]            o_err_count,
  output logic [1:0]            o_state
);
  localparam int BCW = $clog2(PIXEL_BITS + 1);
  localparam logic [LOW_CNT_WIDTH-1:0] LOW_MAX  = LOW_CNT_WIDTH'(RESET_CYCLES);
  localparam logic [LOW_CNT_WIDTH-1:0] LOW_LAST = LOW_CNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [BCW-1:0]           BIT_LAST = BCW'(PIXEL_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_FORWARD = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [LOW_CNT_WIDTH-1:0] low_cnt_q, low_cnt_d;
  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [PIXEL_BITS-1:0]   shift_q, shift_d;
  logic [PIXEL_BITS-1:0]   pixel_data_q, pixel_data_d;
  logic                    pixel_valid_q, pixel_valid_d;
  logic                    fwd_en_q, fwd_en_d;
  logic                    frame_done_q, frame_done_d;
  logic                    overrun_q, overrun_d;
  logic [7:0]              err_count_q, err_count_d;

  logic latch, good_bit, bad_bit, last_bit, pix_complete;

  // The latch fires on the cycle the low run reaches RESET_CYCLES and wins over any strobe.
  always_comb begin
    low_cnt_d = low_cnt_q;
    if (i_rx) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != LOW_MAX) begin
      low_cnt_d = low_cnt_q + 1'b1;
    end
  end

  assign latch    = !i_rx && (low_cnt_q == LOW_LAST);
  assign good_bit = i_bit_strobe && !i_bit_error && !latch;
  assign bad_bit  = i_bit_strobe && i_bit_error && !latch;
  assign last_bit = (bit_cnt_q == BIT_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (latch) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (good_bit)     state_d = S_CAPTURE;
          else if (bad_bit) state_d = S_ERROR;
        end
        S_CAPTURE: begin
          if (bad_bit)                   state_d = S_ERROR;
          else if (good_bit && last_bit) state_d = S_FORWARD;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    pix_complete  = 1'b0;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = pixel_valid_q;
    overrun_d     = 1'b0;
    err_count_d   = err_count_q;

    if (state_q == S_IDLE && good_bit) begin
      shift_d   = {{(PIXEL_BITS-1){1'b0}}, i_bit_value};
      bit_cnt_d = BCW'(1);
    end else if (state_q == S_CAPTURE && good_bit) begin
      shift_d      = {shift_q[PIXEL_BITS-2:0], i_bit_value};
      bit_cnt_d    = bit_cnt_q + 1'b1;
      pix_complete = last_bit;
    end
    if (state_d != S_CAPTURE) bit_cnt_d = '0;

    // A completing pixel may replace the held one only if it is being accepted now.
    if (pix_complete) begin
      if (!pixel_valid_q || i_pixel_ready) begin
        pixel_data_d  = shift_d;
        pixel_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (pixel_valid_q && i_pixel_ready) begin
      pixel_valid_d = 1'b0;
    end

    if (bad_bit && (state_q == S_IDLE || state_q == S_CAPTURE) && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end

    fwd_en_d     = (state_d == S_FORWARD);
    frame_done_d = latch && (state_q != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      low_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      fwd_en_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      err_count_q   <= '0;
    end else begin
      low_cnt_q     <= low_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      fwd_en_q      <= fwd_en_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      err_count_q   <= err_count_d;
    end
  end

  assign o_pixel_data  = pixel_data_q;
  assign o_pixel_valid = pixel_valid_q;
  assign o_fwd_en      = fwd_en_q;
  assign o_frame_done  = frame_done_q;
  assign o_overrun     = overrun_q;
  assign o_err_count   = err_count_q;
  assign o_state       = state_q;
endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Bench for ws2812_frame_ctrl: frame-level vector table, timing sequences, and
// random frames checked against a frame-level reference model.
module tb_ws2812_frame_ctrl;
  localparam int RC = 100;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_rx;
  logic        i_bit_strobe;
  logic        i_bit_value;
  logic        i_bit_error;
  logic [23:0] o_pixel_data;
  logic        o_pixel_valid;
  logic        i_pixel_ready;
  logic        o_fwd_en;
  logic        o_frame_done;
  logic        o_overrun;
  logic [7:0]  o_err_count;
  logic [1:0]  o_state;

  ws2812_frame_ctrl #(.RESET_CYCLES(RC), .LOW_CNT_WIDTH(12), .PIXEL_BITS(24)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rx(i_rx),
    .i_bit_strobe(i_bit_strobe), .i_bit_value(i_bit_value), .i_bit_error(i_bit_error),
    .o_pixel_data(o_pixel_data), .o_pixel_valid(o_pixel_valid), .i_pixel_ready(i_pixel_ready),
    .o_fwd_en(o_fwd_en), .o_frame_done(o_frame_done), .o_overrun(o_overrun),
    .o_err_count(o_err_count), .o_state(o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_cnt   = 0;
  int ov_cnt   = 0;

  always @(negedge i_clk) begin
    if (o_frame_done) fd_cnt++;
    if (o_overrun)    ov_cnt++;
  end

  typedef struct {
    logic [23:0] pix;
    int          nbits;
    int          errpos;
    bit          acc;
    bit          rdy;
    logic [23:0] e_data;
    bit          e_valid;
    int          e_err;
    int          e_ovr;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic accept_pulse();
    i_pixel_ready = 1'b1;
    tick();
    i_pixel_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [23:0] pix, input int nbits, input int errpos, input bit rdy_last);
    for (int i = 0; i < nbits; i++) begin
      i_bit_strobe = 1'b1;
      i_bit_error  = (i == errpos);
      if (i < 24) i_bit_value = pix[23-i];
      else        i_bit_value = 1'($urandom % 2);
      i_pixel_ready = rdy_last && (i == nbits - 1);
      tick();
      i_bit_strobe  = 1'b0;
      i_bit_error   = 1'b0;
      i_pixel_ready = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        i_rx = 1'($urandom % 2);
        tick();
      end
      i_rx = 1'b1;
    end
  endtask

  task automatic do_latch();
    i_rx = 1'b0;
    repeat (RC) tick();
    i_rx = 1'b1;
    tick();
  endtask

  logic [23:0] m_data;
  bit          m_valid;
  int          m_err;
  int          fd0, ov0, exp_ovr;
  logic [23:0] pat;

  initial begin
    tbl[0] = '{24'h123456, 24, -1, 1'b0, 1'b0, 24'h123456, 1'b1, 0, 0};
    tbl[1] = '{24'hFF0000, 24, -1, 1'b1, 1'b0, 24'hFF0000, 1'b1, 0, 0};
    tbl[2] = '{24'h00FF00, 24, -1, 1'b0, 1'b0, 24'hFF0000, 1'b1, 0, 1};
    tbl[3] = '{24'hABCDEF, 24, 10, 1'b1, 1'b0, 24'hFF0000, 1'b0, 1, 0};
    tbl[4] = '{24'h0F0F0F, 24, -1, 1'b0, 1'b0, 24'h0F0F0F, 1'b1, 1, 0};
    tbl[5] = '{24'h55AA33, 24, -1, 1'b0, 1'b1, 24'h55AA33, 1'b1, 1, 0};
    tbl[6] = '{24'h777777, 12, -1, 1'b1, 1'b0, 24'h55AA33, 1'b0, 1, 0};
    tbl[7] = '{24'h000001, 24,  0, 1'b0, 1'b0, 24'h55AA33, 1'b0, 2, 0};
    tbl[8] = '{24'hC3C3C3, 30, 26, 1'b0, 1'b0, 24'hC3C3C3, 1'b1, 2, 0};

    i_reset_n = 1'b0; i_rx = 1'b1; i_bit_strobe = 1'b0; i_bit_value = 1'b0;
    i_bit_error = 1'b0; i_pixel_ready = 1'b0;
    repeat (3) tick();
    i_reset_n = 1'b1;
    check("rst_data", 32'(o_pixel_data), 32'h0);
    check("rst_valid", 32'(o_pixel_valid), 32'h0);
    check("rst_fwd", 32'(o_fwd_en), 32'h0);
    check("rst_done", 32'(o_frame_done), 32'h0);
    check("rst_ovr", 32'(o_overrun), 32'h0);
    check("rst_err", 32'(o_err_count), 32'h0);
    check("rst_state", 32'(o_state), 32'h0);

    foreach (tbl[k]) begin
      fd0 = fd_cnt; ov0 = ov_cnt;
      if (tbl[k].acc) accept_pulse();
      send_frame(tbl[k].pix, tbl[k].nbits, tbl[k].errpos, tbl[k].rdy);
      do_latch();
      $display("vec %0d: pix=%h bits=%0d err@%0d -> data=%h valid=%0d errs=%0d",
               k, tbl[k].pix, tbl[k].nbits, tbl[k].errpos, o_pixel_data, o_pixel_valid, o_err_count);
      check($sformatf("vec%0d_data", k), 32'(o_pixel_data), 32'(tbl[k].e_data));
      check($sformatf("vec%0d_valid", k), 32'(o_pixel_valid), 32'(tbl[k].e_valid));
      check($sformatf("vec%0d_err", k), 32'(o_err_count), 32'(tbl[k].e_err));
      check($sformatf("vec%0d_ovr", k), 32'(ov_cnt - ov0), 32'(tbl[k].e_ovr));
      check($sformatf("vec%0d_done", k), 32'(fd_cnt - fd0), 32'd1);
      check($sformatf("vec%0d_state", k), 32'(o_state), 32'd0);
      check($sformatf("vec%0d_fwd", k), 32'(o_fwd_en), 32'd0);
    end

    // Capture latency and latch timing with back-to-back strobes.
    accept_pulse();
    check("acc_clears_valid", 32'(o_pixel_valid), 32'd0);
    pat = 24'h123456;
    fd0 = fd_cnt;
    for (int i = 0; i < 24; i++) begin
      i_bit_strobe = 1'b1; i_bit_value = pat[23-i];
      tick();
      if (i == 22) begin
        check("b23_valid", 32'(o_pixel_valid), 32'd0);
        check("b23_state", 32'(o_state), 32'd1);
        check("b23_fwd", 32'(o_fwd_en), 32'd0);
      end
    end
    i_bit_strobe = 1'b0;
    check("b24_valid", 32'(o_pixel_valid), 32'd1);
    check("b24_data", 32'(o_pixel_data), 32'h123456);
    check("b24_fwd", 32'(o_fwd_en), 32'd1);
    check("b24_state", 32'(o_state), 32'd2);
    i_rx = 1'b0;
    repeat (RC - 1) tick();
    check("pre_latch_fwd", 32'(o_fwd_en), 32'd1);
    check("pre_latch_done", 32'(o_frame_done), 32'd0);
    tick();
    check("latch_state", 32'(o_state), 32'd0);
    check("latch_fwd", 32'(o_fwd_en), 32'd0);
    check("latch_done", 32'(o_frame_done), 32'd1);
    tick();
    check("latch_done_low", 32'(o_frame_done), 32'd0);
    i_rx = 1'b1;
    tick();
    check("latch_single_pulse", 32'(fd_cnt - fd0), 32'd1);
    $display("seq latch: data=%h fwd=%0d state=%0d", o_pixel_data, o_fwd_en, o_state);

    // Two low runs of RC-1 split by one high cycle must not latch.
    accept_pulse();
    send_frame(24'h0000AA, 24, -1, 1'b0);
    fd0 = fd_cnt;
    i_rx = 1'b0; repeat (RC - 1) tick();
    i_rx = 1'b1; tick();
    i_rx = 1'b0; repeat (RC - 1) tick();
    check("nolatch_state", 32'(o_state), 32'd2);
    check("nolatch_fwd", 32'(o_fwd_en), 32'd1);
    check("nolatch_done", 32'(fd_cnt - fd0), 32'd0);
    $display("seq nolatch: state=%0d fwd=%0d", o_state, o_fwd_en);
    i_rx = 1'b1; tick();
    do_latch();

    // Mid-capture reset clears everything, including the error count.
    accept_pulse();
    send_frame(24'hFFFFFF, 12, -1, 1'b0);
    check("pre_rst_state", 32'(o_state), 32'd1);
    i_reset_n = 1'b0; tick(); i_reset_n = 1'b1;
    check("mid_rst_state", 32'(o_state), 32'd0);
    check("mid_rst_err", 32'(o_err_count), 32'd0);
    check("mid_rst_data", 32'(o_pixel_data), 32'd0);
    check("mid_rst_valid", 32'(o_pixel_valid), 32'd0);
    send_frame(24'h5A5A5A, 24, -1, 1'b0);
    do_latch();
    check("post_rst_data", 32'(o_pixel_data), 32'h5A5A5A);
    check("post_rst_valid", 32'(o_pixel_valid), 32'd1);
    $display("seq reset: data=%h valid=%0d", o_pixel_data, o_pixel_valid);

    // Random frames against a frame-level model.
    m_data = 24'h5A5A5A; m_valid = 1'b1; m_err = 0;
    for (int f = 0; f < 40; f++) begin
      logic [23:0] pix;
      int nb, ep;
      bit acc, rl, errored, complete;
      pix = 24'($urandom);
      nb  = $urandom_range(1, 30);
      ep  = ($urandom % 3 == 0) ? $urandom_range(0, 29) : -1;
      acc = 1'($urandom % 2);
      rl  = 1'($urandom % 2);
      errored  = (ep >= 0) && (ep < nb) && (ep < 24);
      complete = (nb >= 24) && !errored;
      exp_ovr  = 0;
      if (acc) m_valid = 1'b0;
      if (errored && m_err < 255) m_err++;
      if (complete && nb == 24 && rl) begin
        m_data = pix; m_valid = 1'b1;
      end else begin
        if (complete) begin
          if (m_valid) exp_ovr = 1;
          else begin m_data = pix; m_valid = 1'b1; end
        end
        if (rl) m_valid = 1'b0;
      end
      fd0 = fd_cnt; ov0 = ov_cnt;
      if (acc) accept_pulse();
      send_frame(pix, nb, ep, rl);
      do_latch();
      $display("rnd %0d: pix=%h bits=%0d err@%0d rdy=%0d -> data=%h valid=%0d errs=%0d",
               f, pix, nb, ep, rl, o_pixel_data, o_pixel_valid, o_err_count);
      check("rnd_data", 32'(o_pixel_data), 32'(m_data));
      check("rnd_valid", 32'(o_pixel_valid), 32'(m_valid));
      check("rnd_err", 32'(o_err_count), 32'(m_err));
      check("rnd_ovr", 32'(ov_cnt - ov0), 32'(exp_ovr));
      check("rnd_done", 32'(fd_cnt - fd0), 32'd1);
      check("rnd_state", 32'(o_state), 32'd0);
    end

    // 256 error frames saturate the error counter.
    for (int f = 0; f < 256; f++) begin
      send_frame(24'h0, 1, 0, 1'b0);
      do_latch();
      if (m_err < 255) m_err++;
    end
    $display("seq saturate: errs=%0d", o_err_count);
    check("sat_err_model", 32'(o_err_count), 32'(m_err));
    check("sat_err_255", 32'(o_err_count), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
